// File: rtl/tage_update_queue.sv
// tage_update_queue: in-flight prediction FIFO that turns execute resolutions into TAGE update strobes.
// Optional misprediction counter enabled by macro TAGE_UPDQ_STATS_EN.
module tage_update_queue #(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     pred_valid_i,
    input  logic [31:0]              pred_idx_i,
    input  logic                     pred_taken_i,
    input  logic [31:0]              pred_targ_i,
    output logic                     pred_ready_o,
    input  logic                     res_valid_i,
    input  logic                     res_taken_i,
    input  logic [31:0]              res_targ_i,
    output logic                     upd_valid_o,
    output logic [31:0]              upd_idx_o,
    output logic                     upd_br_result_o,
    output logic                     upd_correct_o,
    output logic                     flush_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     err_o
`ifdef TAGE_UPDQ_STATS_EN
    ,
    output logic [31:0]              mispred_cnt_o
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

    typedef enum logic {S_RUN, S_FLUSH} state_t;

    state_t          r_state, w_state_n;
    logic [31:0]     r_idx  [DEPTH];
    logic            r_taken[DEPTH];
    logic [31:0]     r_targ [DEPTH];
    logic [AW-1:0]   r_head, r_tail;
    logic [AW:0]     r_count;
    logic            r_upd_valid, r_upd_br, r_upd_correct, r_err;
    logic [31:0]     r_upd_idx;
    logic            w_run, w_pop, w_push, w_correct, w_mis;

    assign w_run        = (r_state == S_RUN);
    assign w_pop        = w_run && res_valid_i && (r_count != '0);
    assign pred_ready_o = w_run && ((r_count < L_FULL) || w_pop);
    assign w_push       = pred_valid_i && pred_ready_o;
    // A not-taken resolution is correct regardless of the stored target.
    assign w_correct    = (res_taken_i == r_taken[r_head]) &&
                          (!res_taken_i || (res_targ_i == r_targ[r_head]));
    assign w_mis        = w_pop && !w_correct;

    always_comb begin
        w_state_n = (w_run && w_mis) ? S_FLUSH : S_RUN;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_idx[r_tail]   <= pred_idx_i;
            r_taken[r_tail] <= pred_taken_i;
            r_targ[r_tail]  <= pred_targ_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_mis) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= w_pop  ? r_head + 1'b1 : r_head;
            r_tail  <= w_push ? r_tail + 1'b1 : r_tail;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_upd_valid   <= 1'b0;
            r_upd_idx     <= '0;
            r_upd_br      <= 1'b0;
            r_upd_correct <= 1'b1;
            r_err         <= 1'b0;
        end else begin
            r_upd_valid <= w_pop;
            if (w_pop) begin
                r_upd_idx     <= r_idx[r_head];
                r_upd_br      <= res_taken_i;
                r_upd_correct <= w_correct;
            end
            if (w_run && res_valid_i && (r_count == '0)) r_err <= 1'b1;
        end
    end

`ifdef TAGE_UPDQ_STATS_EN
    logic [31:0] r_mispred_cnt;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mispred_cnt <= '0;
        end else if (w_mis && (r_mispred_cnt != 32'hFFFF_FFFF)) begin
            r_mispred_cnt <= r_mispred_cnt + 32'd1;
        end
    end
    assign mispred_cnt_o = r_mispred_cnt;
`endif

    assign upd_valid_o     = r_upd_valid;
    assign upd_idx_o       = r_upd_idx;
    assign upd_br_result_o = r_upd_br;
    assign upd_correct_o   = r_upd_correct;
    assign flush_o         = (r_state == S_FLUSH);
    assign count_o         = r_count;
    assign err_o           = r_err;
endmodule

// File: tb/tb_tage_update_queue.sv
// tb_tage_update_queue: directed checks of the TAGE update queue with DEPTH=8.
module tb_tage_update_queue;
    logic        clk = 1'b0;
    logic        rst_i;
    logic        pred_valid_i, pred_taken_i, pred_ready_o;
    logic [31:0] pred_idx_i, pred_targ_i;
    logic        res_valid_i, res_taken_i;
    logic [31:0] res_targ_i;
    logic        upd_valid_o, upd_br_result_o, upd_correct_o, flush_o, err_o;
    logic [31:0] upd_idx_o;
    logic [3:0]  count_o;
`ifdef TAGE_UPDQ_STATS_EN
    logic [31:0] mispred_cnt_o;
`endif
    int n_cmp = 0;
    int n_bad = 0;

    tage_update_queue #(.DEPTH(8)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .pred_valid_i(pred_valid_i), .pred_idx_i(pred_idx_i),
        .pred_taken_i(pred_taken_i), .pred_targ_i(pred_targ_i),
        .pred_ready_o(pred_ready_o),
        .res_valid_i(res_valid_i), .res_taken_i(res_taken_i), .res_targ_i(res_targ_i),
        .upd_valid_o(upd_valid_o), .upd_idx_o(upd_idx_o),
        .upd_br_result_o(upd_br_result_o), .upd_correct_o(upd_correct_o),
        .flush_o(flush_o), .count_o(count_o), .err_o(err_o)
`ifdef TAGE_UPDQ_STATS_EN
        , .mispred_cnt_o(mispred_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic [31:0] pidx, input logic pt,
                         input logic [31:0] ptarg, input logic rv, input logic rt,
                         input logic [31:0] rtarg);
        pred_valid_i = pv; pred_idx_i = pidx; pred_taken_i = pt; pred_targ_i = ptarg;
        res_valid_i = rv; res_taken_i = rt; res_targ_i = rtarg;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        rst_i = 1'b1;
        idle();
        tick();
        tick();
        rst_i = 1'b0;
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_upd_valid", 64'(upd_valid_o), 64'd0);
        check("rst_upd_idx", 64'(upd_idx_o), 64'd0);
        check("rst_upd_br", 64'(upd_br_result_o), 64'd0);
        check("rst_upd_correct", 64'(upd_correct_o), 64'd1);
        check("rst_flush", 64'(flush_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_ready", 64'(pred_ready_o), 64'd1);

        // Three correct predictions
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h100 + 32'(4*i), 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
            tick();
        end
        idle();
        check("a_count3", 64'(count_o), 64'd3);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200);
            tick();
            check("a_upd_valid", 64'(upd_valid_o), 64'd1);
            check("a_upd_idx", 64'(upd_idx_o), 64'h100 + 64'(4*i));
            check("a_upd_br", 64'(upd_br_result_o), 64'd1);
            check("a_correct", 64'(upd_correct_o), 64'd1);
            check("a_flush", 64'(flush_o), 64'd0);
            check("a_count", 64'(count_o), 64'(2-i));
        end
        idle();
        tick();
        check("a_idle_valid", 64'(upd_valid_o), 64'd0);
        check("a_idle_hold", 64'(upd_idx_o), 64'h108);

        // Fill to full, drop the 9th, then push+pop while full
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h1000 + 32'(4*i), 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
            tick();
        end
        drive(1'b1, 32'h1020, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
        check("b_full_count", 64'(count_o), 64'd8);
        check("b_full_ready", 64'(pred_ready_o), 64'd0);
        tick();
        check("b_drop_count", 64'(count_o), 64'd8);
        drive(1'b1, 32'h2000, 1'b1, 32'h200, 1'b1, 1'b1, 32'h200);
        check("b_pp_ready", 64'(pred_ready_o), 64'd1);
        tick();
        check("b_pp_count", 64'(count_o), 64'd8);
        check("b_pp_idx", 64'(upd_idx_o), 64'h1000);
        check("b_pp_correct", 64'(upd_correct_o), 64'd1);
        for (int i = 1; i < 9; i++) begin
            drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200);
            tick();
            check("b_drain_idx", 64'(upd_idx_o), (i < 8) ? 64'h1000 + 64'(4*i) : 64'h2000);
        end
        idle();
        check("b_empty", 64'(count_o), 64'd0);

        // Direction mispredict with a same-cycle push that must be discarded
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h300 + 32'(4*i), 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
            tick();
        end
        drive(1'b1, 32'h3f0, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0);
        tick();
        drive(1'b1, 32'h3f4, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0);
        check("c_upd_valid", 64'(upd_valid_o), 64'd1);
        check("c_upd_idx", 64'(upd_idx_o), 64'h300);
        check("c_upd_br", 64'(upd_br_result_o), 64'd0);
        check("c_correct", 64'(upd_correct_o), 64'd0);
        check("c_flush", 64'(flush_o), 64'd1);
        check("c_count", 64'(count_o), 64'd0);
        check("c_ready", 64'(pred_ready_o), 64'd0);
`ifdef TAGE_UPDQ_STATS_EN
        check("c_mispred_cnt", 64'(mispred_cnt_o), 64'd1);
`endif
        tick();
        idle();
        check("c_after_flush", 64'(flush_o), 64'd0);
        check("c_after_valid", 64'(upd_valid_o), 64'd0);
        check("c_after_count", 64'(count_o), 64'd0);
        check("c_after_err", 64'(err_o), 64'd0);
        check("c_after_ready", 64'(pred_ready_o), 64'd1);

        // Target mispredict
        drive(1'b1, 32'h500, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h300);
        tick();
        idle();
        check("d_correct", 64'(upd_correct_o), 64'd0);
        check("d_flush", 64'(flush_o), 64'd1);
        check("d_idx", 64'(upd_idx_o), 64'h500);
`ifdef TAGE_UPDQ_STATS_EN
        check("d_mispred_cnt", 64'(mispred_cnt_o), 64'd2);
`endif
        tick();

        // Predicted and resolved not-taken: targets are irrelevant
        drive(1'b1, 32'h600, 1'b0, 32'h111, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h999);
        tick();
        idle();
        check("nt_correct", 64'(upd_correct_o), 64'd1);
        check("nt_flush", 64'(flush_o), 64'd0);

        // Resolve on empty queue
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200);
        tick();
        idle();
        check("e_err", 64'(err_o), 64'd1);
        check("e_no_upd", 64'(upd_valid_o), 64'd0);
        tick();
        check("e_sticky", 64'(err_o), 64'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("e_rst_clears", 64'(err_o), 64'd0);

        // 20 pushes / 20 pops interleaved, wrapping the pointers
        for (int c = 0; c < 22; c++) begin
            drive(c < 20, 32'h4000 + 32'(4*c), 1'b1, 32'h200, c >= 2, 1'b1, 32'h200);
            tick();
            if (c >= 2) begin
                check("f_valid", 64'(upd_valid_o), 64'd1);
                check("f_idx", 64'(upd_idx_o), 64'h4000 + 64'(4*(c-2)));
            end
        end
        idle();
        check("f_count", 64'(count_o), 64'd0);
        check("f_err", 64'(err_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
